// File: rtl/uart_tx_controller.sv
// UART transmitter: start bit, DATA_BITS payload LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the parity bit between the data bits and the stop bit.
module uart_tx_controller #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t                 state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   serial_q, serial_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   baud_end;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        serial_d = serial_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            IDLE: begin
                baud_d   = '0;
                bit_d    = '0;
                serial_d = 1'b1;
                busy_d   = 1'b0;
                if (tx_start) begin
                    state_d  = START;
                    shift_d  = tx_data;
                    serial_d = 1'b0;
                    busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                end
            end

            START: begin
                if (baud_end) begin
                    state_d  = DATA;
                    baud_d   = '0;
                    serial_d = shift_q[0];
                    shift_d  = shift_q >> 1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            // The shift register always presents the next payload bit at bit 0.
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d  = PARITY;
                        serial_d = parity_q;
`else
                        state_d  = STOP;
                        serial_d = 1'b1;
`endif
                    end else begin
                        bit_d    = bit_q + 1'b1;
                        serial_d = shift_q[0];
                        shift_d  = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    state_d  = STOP;
                    baud_d   = '0;
                    serial_d = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif

            STOP: begin
                if (baud_end) begin
                    state_d  = IDLE;
                    baud_d   = '0;
                    serial_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                state_d  = IDLE;
                baud_d   = '0;
                bit_d    = '0;
                serial_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    // Reset aborts any frame in flight: line high, no done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx_serial = serial_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Bench for uart_tx_controller: frame decoder with scoreboard on a 4-clk/8-bit instance,
// plus a 2-clk/5-bit instance checked bit by bit.
module tb_uart_tx_controller;

    localparam int CA = 4;
    localparam int DA = 8;
    localparam int CB = 2;
    localparam int DB = 5;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBA = DA + 2 + PAR;
    localparam int NBB = DB + 2 + PAR;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_start_a, tx_serial_a, tx_busy_a, tx_done_a;
    logic [DA-1:0] tx_data_a;
    logic          tx_start_b, tx_serial_b, tx_busy_b, tx_done_b;
    logic [DB-1:0] tx_data_b;

    int n_chk   = 0;
    int n_pass  = 0;
    int stray   = 0;
    int aborted = 0;
    logic [DA-1:0] sb_a[$];
    logic [DB-1:0] sb_b[$];

    always #5 clk = ~clk;

    uart_tx_controller #(.CLKS_PER_BIT(CA), .DATA_BITS(DA)) dut_a (
        .clk(clk), .reset(rst), .tx_start(tx_start_a), .tx_data(tx_data_a),
        .tx_serial(tx_serial_a), .tx_busy(tx_busy_a), .tx_done(tx_done_a)
    );

    uart_tx_controller #(.CLKS_PER_BIT(CB), .DATA_BITS(DB)) dut_b (
        .clk(clk), .reset(rst), .tx_start(tx_start_b), .tx_data(tx_data_b),
        .tx_serial(tx_serial_b), .tx_busy(tx_busy_b), .tx_done(tx_done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    endtask

    // Decode one frame on instance A, starting at the first start-bit sample.
    task automatic rx_frame_a();
        logic [15:0]   bits;
        logic [DA-1:0] exp, got;
        int            unstable, busy_hi;
        bits = '0; got = '0; exp = '0; unstable = 0; busy_hi = 0;
        check("a_sb_nonempty", sb_a.size() > 0, 1);
        if (sb_a.size() > 0) exp = sb_a.pop_front();
        for (int k = 0; k < NBA; k++) begin
            for (int c = 0; c < CA; c++) begin
                if (k != 0 || c != 0) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted++;
                        return;
                    end
                end
                if (tx_busy_a) busy_hi++;
                if (tx_done_a) stray++;
                if (c == 0) bits[k] = tx_serial_a;
                else if (tx_serial_a !== bits[k]) unstable++;
            end
        end
        @(negedge clk);
        if (rst) begin
            aborted++;
            return;
        end
        for (int i = 0; i < DA; i++) got[i] = bits[i+1];
        check("a_data", got, exp);
`ifdef UART_TX_PARITY_EN
        check("a_parity", bits[DA+1], ^exp);
`endif
        check("a_stop", bits[NBA-1], 1);
        check("a_bit_stable", unstable, 0);
        check("a_busy_len", busy_hi, NBA * CA);
        check("a_done_pulse", tx_done_a, 1);
        check("a_idle_busy", tx_busy_a, 0);
        check("a_idle_line", tx_serial_a, 1);
    endtask

    initial begin : mon_a
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_done_a) stray++;
            if (rst) begin
                prev = 1'b1;
            end else begin
                if (prev && tx_serial_a === 1'b0) rx_frame_a();
                prev = tx_serial_a;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_a(input logic [DA-1:0] d);
        tx_data_a  = d;
        tx_start_a = 1'b1;
        sb_a.push_back(d);
        step();
        tx_start_a = 1'b0;
    endtask

    task automatic wait_done_a();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_done_a !== 1'b1 && n < 400);
        check("a_done_seen", tx_done_a, 1);
    endtask

    task automatic frame_b(input logic [DB-1:0] d);
        logic [DB-1:0] exp;
        logic          lvl;
        int            err, bcnt, k;
        err = 0; bcnt = 0; exp = '0;
        tx_data_b  = d;
        tx_start_b = 1'b1;
        sb_b.push_back(d);
        step();
        tx_start_b = 1'b0;
        check("b_sb_nonempty", sb_b.size() > 0, 1);
        if (sb_b.size() > 0) exp = sb_b.pop_front();
        for (int i = 0; i < NBB * CB; i++) begin
            k = i / CB;
            @(negedge clk);
            if (k == 0) lvl = 1'b0;
            else if (k <= DB) lvl = exp[k-1];
            else if (PAR == 1 && k == DB + 1) lvl = ^exp;
            else lvl = 1'b1;
            if (tx_serial_b !== lvl) err++;
            if (tx_busy_b) bcnt++;
        end
        check("b_line", err, 0);
        check("b_busy_len", bcnt, NBB * CB);
        @(negedge clk);
        check("b_done_pulse", tx_done_b, 1);
        check("b_idle_busy", tx_busy_b, 0);
        @(negedge clk);
        check("b_done_once", tx_done_b, 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: observed no end, required completion");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        logic [DA-1:0] pats[4];
        pats[0] = 8'hA5; pats[1] = 8'h07; pats[2] = 8'h00; pats[3] = 8'hFF;
        rst = 1'b0; tx_start_a = 1'b0; tx_data_a = '0; tx_start_b = 1'b0; tx_data_b = '0;
        #3 rst = 1'b1;
        #1;
        check("rst_line_a", tx_serial_a, 1);
        check("rst_busy_a", tx_busy_a, 0);
        check("rst_done_a", tx_done_a, 0);
        check("rst_line_b", tx_serial_b, 1);
        check("rst_busy_b", tx_busy_b, 0);
        step();
        step();

        // First edge with reset low accepts the request.
        rst = 1'b0;
        send_a(8'h55);
        check("first_accept_busy", tx_busy_a, 1);
        check("first_accept_line", tx_serial_a, 0);
        wait_done_a();

        for (int i = 0; i < 4; i++) begin
            repeat (3) step();
            send_a(pats[i]);
            wait_done_a();
        end

        // Held start: two frames separated by exactly the done cycle.
        repeat (2) step();
        tx_data_a  = 8'h3C;
        tx_start_a = 1'b1;
        sb_a.push_back(8'h3C);
        step();
        tx_data_a = 8'hC3;
        sb_a.push_back(8'hC3);
        wait_done_a();
        step();
        tx_start_a = 1'b0;
        check("b2b_restart_busy", tx_busy_a, 1);
        check("b2b_restart_line", tx_serial_a, 0);
        wait_done_a();

        // Request and data change mid-frame are ignored.
        repeat (3) step();
        send_a(8'h12);
        repeat (8) step();
        tx_data_a  = 8'hFF;
        tx_start_a = 1'b1;
        step();
        tx_start_a = 1'b0;
        wait_done_a();
        repeat (3 * NBA * CA) @(negedge clk);
        check("no_extra_frame", tx_busy_a, 0);

        // Reset during data bit 3 (0xB4 bit 3 is 0).
        repeat (2) step();
        send_a(8'hB4);
        repeat (16) step();
        check("pre_reset_busy", tx_busy_a, 1);
        check("pre_reset_line", tx_serial_a, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_line", tx_serial_a, 1);
        check("mid_rst_busy", tx_busy_a, 0);
        check("mid_rst_done", tx_done_a, 0);
        step();
        check("held_rst_done", tx_done_a, 0);
        rst = 1'b0;
        send_a(8'h69);
        wait_done_a();

        repeat (2) step();
        frame_b(5'h1F);
        repeat (2) step();
        frame_b(5'h0A);

        repeat (4) step();
        check("stray_done", stray, 0);
        check("aborted_frames", aborted, 1);
        check("sb_a_drained", sb_a.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_controller.md
UART_TX_CONTROLLER -- requirements
Module: uart_tx_controller

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..65535.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port tx_start  input  1  frame request, sampled only in IDLE.
REQ-006 The block SHALL have port tx_data  input  DATA_BITS  frame payload, captured when tx_start is accepted.
REQ-007 The block SHALL have port tx_serial  output  1  registered serial line; idle level 1.
REQ-008 The block SHALL have port tx_busy  output  1  high while a frame is on the line.
REQ-009 The block SHALL have port tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-010 The FSM SHALL have states IDLE, START, DATA, PARITY (only when REQ-026 applies) and STOP.
REQ-011 In IDLE with tx_start=1 at edge N, the block SHALL capture tx_data into a shift register and enter START at edge N, so tx_serial=0 and tx_busy=1 from cycle N+1.
REQ-012 A baud counter SHALL count 0..CLKS_PER_BIT-1 in every non-IDLE state; its width is ceil(log2(CLKS_PER_BIT)) bits; it clears on every state change.
REQ-013 Each state SHALL last exactly CLKS_PER_BIT cycles per bit; the transition occurs on the edge where the baud counter equals CLKS_PER_BIT-1.
REQ-014 DATA SHALL transmit the captured bits LSB first; a bit counter 0..DATA_BITS-1 SHALL advance on each bit boundary, and DATA exits after bit DATA_BITS-1.
REQ-015 STOP SHALL drive tx_serial=1 for one bit time, then return to IDLE.
REQ-016 tx_busy SHALL be 0 in IDLE and 1 in all other states; busy duration is (DATA_BITS+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT when parity is enabled.
REQ-017 tx_done SHALL be 1 for exactly one cycle, the first IDLE cycle after STOP, and 0 otherwise.
REQ-018 tx_start while tx_busy=1 SHALL be ignored; tx_data changes during a frame SHALL NOT affect the frame.
REQ-019 tx_start=1 in the cycle where tx_done=1 SHALL be accepted, giving back-to-back frames with exactly one idle-high cycle between stop and the next start bit.
REQ-020 tx_start held high continuously SHALL produce consecutive frames per REQ-019.

Reset
REQ-021 reset=1 SHALL immediately, independent of clk, force the state to IDLE, tx_serial=1, tx_busy=0, tx_done=0, and the baud counter, bit counter and shift register to 0.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no tx_done pulse; the line returns high at once.
REQ-023 After reset deassertion, the first tx_start SHALL be accepted on the first rising edge where reset=0.

Configuration
REQ-024 The parity feature SHALL be controlled by the macro UART_TX_PARITY_EN.
REQ-025 Without UART_TX_PARITY_EN, DATA SHALL go directly to STOP and no parity logic SHALL exist.
REQ-026 With UART_TX_PARITY_EN, the PARITY state SHALL follow DATA for one bit time, driving even parity (XOR of the captured DATA_BITS bits), then go to STOP.

Verification
REQ-027 CLKS_PER_BIT=4, no parity, tx_data=0x55 -> tx_serial 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each held 4 cycles; tx_busy high 40 cycles; tx_done one pulse.
REQ-028 Parity enabled, CLKS_PER_BIT=4: tx_data=0xA5 -> parity bit 0; tx_data=0x07 -> parity bit 1; tx_busy high 44 cycles.
REQ-029 tx_start held high with data 0x3C then 0xC3 -> two frames; exactly 1 idle-high cycle between them, coincident with tx_done.
REQ-030 Pulse tx_start with 0x12 at cycle 10 of the frame and change tx_data to 0xFF -> ignored; frame still carries 0x12; no extra frame follows.
REQ-031 Assert reset during DATA bit 3 -> same cycle: tx_serial=1, tx_busy=0, no tx_done; a new tx_start after release sends a full correct frame.
REQ-032 CLKS_PER_BIT=2, DATA_BITS=5, tx_data=0x1F -> 7 bits of 2 cycles each; busy 14 cycles.
